// File: rtl/cache_controller_nway_wb.sv
// rtl/cache_controller_nway_wb.sv - N-way set-associative write-back, write-allocate cache controller
//
// Tag, valid, dirty and round-robin replacement state live here; line data is
// held in an external per-way array (combinational read, synchronous write).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_req_*, cpu_addr,
//   cpu_wdata, cpu_wstrb     CPU request (load/store, byte strobes)
//   cpu_ready                request accepted this cycle (IDLE)
//   cpu_resp_valid, cpu_rdata,
//   cpu_hit                  one-cycle response, held load data, hit flag
//   flush_req, flush_done    write back all dirty lines and invalidate
//   cache_mem_*              external line data array (index/way/write)
//   mem_*                    line-granular main memory handshake
module cache_controller_nway_wb #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 64,
    parameter int SETS       = 64,
    parameter int WAYS       = 2,
    localparam int OFF_W     = $clog2(LINE_BYTES),
    localparam int IDX_W     = $clog2(SETS),
    localparam int TAG_W     = ADDR_W - IDX_W - OFF_W,
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int LINE_W    = 8 * LINE_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    input  logic                  cpu_req_write,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic [3:0]            cpu_wstrb,
    output logic                  cpu_ready,
    output logic                  cpu_resp_valid,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_hit,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic [IDX_W-1:0]      cache_mem_index,
    output logic [WAY_W-1:0]      cache_mem_way,
    output logic [LINE_W-1:0]     cache_mem_wdata,
    output logic [LINE_BYTES-1:0] cache_mem_wstrb,
    output logic                  cache_mem_write_en,
    input  logic [LINE_W-1:0]     cache_mem_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd_req,
    output logic                  mem_wr_req,
    output logic [LINE_W-1:0]     mem_wdata,
    input  logic [LINE_W-1:0]     mem_rdata,
    input  logic                  mem_ready
);

    localparam int WORDS  = LINE_BYTES / 4;
    localparam int WORD_W = OFF_W - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_REFILL,
        S_RESPOND,
        S_FLUSH_SCAN,
        S_FLUSH_WB
    } state_t;

    state_t state, next_state;

    // Per-entry bookkeeping
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [WAY_W-1:0] rr_q    [SETS];

    // Latched request
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_set;
    logic [WORD_W-1:0] req_word;
    logic              req_write;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;

    logic [WAY_W-1:0]  victim_q;
    logic              resp_hit_q;
    logic [31:0]       rdata_q;
    logic              flush_done_q;
    logic [IDX_W-1:0]  scan_set;
    logic [WAY_W-1:0]  scan_way;

    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    // Tag compare and victim choice for the latched set
    logic              lookup_hit;
    logic [WAY_W-1:0]  hit_way;
    logic              any_invalid;
    logic [WAY_W-1:0]  invalid_way;
    logic [WAY_W-1:0]  victim_sel;

    always_comb begin
        lookup_hit  = 1'b0;
        hit_way     = '0;
        any_invalid = 1'b0;
        invalid_way = '0;
        // Descending loop so the lowest matching index wins
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
                lookup_hit = 1'b1;
                hit_way    = WAY_W'(w);
            end
            if (!valid_q[req_set][w]) begin
                any_invalid = 1'b1;
                invalid_way = WAY_W'(w);
            end
        end
        victim_sel = any_invalid ? invalid_way : rr_q[req_set];
    end

    // Refill line with store bytes merged in on a write miss
    logic [LINE_W-1:0] merged_line;

    always_comb begin
        merged_line = mem_rdata;
        if (req_write) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wstrb[b]) begin
                    merged_line[{req_word, 5'b0} + 8 * b +: 8] = req_wdata[8 * b +: 8];
                end
            end
        end
    end

    logic             scan_last;
    logic             scan_entry_dirty;
    logic             scan_adv;
    logic [WAY_W-1:0] rr_next;

    assign scan_last        = (scan_set == IDX_W'(SETS - 1)) && (scan_way == WAY_W'(WAYS - 1));
    assign scan_entry_dirty = dirty_q[scan_set][scan_way];
    assign scan_adv         = ((state == S_FLUSH_SCAN) && !scan_entry_dirty) ||
                              ((state == S_FLUSH_WB) && mem_ready);
    assign rr_next          = (rr_q[req_set] == WAY_W'(WAYS - 1)) ? '0 : rr_q[req_set] + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state         = state;
        cpu_ready          = 1'b0;
        cpu_resp_valid     = 1'b0;
        cache_mem_index    = req_set;
        cache_mem_way      = '0;
        cache_mem_wdata    = '0;
        cache_mem_wstrb    = '0;
        cache_mem_write_en = 1'b0;
        mem_addr           = '0;
        mem_rd_req         = 1'b0;
        mem_wr_req         = 1'b0;
        mem_wdata          = '0;

        case (state)
            S_IDLE: begin
                cpu_ready = 1'b1;
                if (flush_req) begin
                    next_state = S_FLUSH_SCAN;
                end else if (cpu_req_valid) begin
                    next_state = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                cache_mem_way = lookup_hit ? hit_way : victim_sel;
                if (lookup_hit) begin
                    if (req_write) begin
                        cache_mem_write_en = 1'b1;
                        cache_mem_wdata    = {WORDS{req_wdata}};
                        cache_mem_wstrb    = LINE_BYTES'(req_wstrb) << {req_word, 2'b00};
                    end
                    next_state = S_RESPOND;
                end else if (valid_q[req_set][victim_sel] && dirty_q[req_set][victim_sel]) begin
                    next_state = S_WRITEBACK;
                end else begin
                    next_state = S_REFILL;
                end
            end
            S_WRITEBACK: begin
                cache_mem_way = victim_q;
                mem_wr_req    = 1'b1;
                mem_addr      = {tag_q[req_set][victim_q], req_set, {OFF_W{1'b0}}};
                mem_wdata     = cache_mem_rdata;
                if (mem_ready) begin
                    next_state = S_REFILL;
                end
            end
            S_REFILL: begin
                cache_mem_way = victim_q;
                mem_rd_req    = 1'b1;
                mem_addr      = {req_tag, req_set, {OFF_W{1'b0}}};
                if (mem_ready) begin
                    cache_mem_write_en = 1'b1;
                    cache_mem_wstrb    = '1;
                    cache_mem_wdata    = merged_line;
                    next_state         = S_RESPOND;
                end
            end
            S_RESPOND: begin
                cpu_resp_valid = 1'b1;
                next_state     = S_IDLE;
            end
            S_FLUSH_SCAN: begin
                cache_mem_index = scan_set;
                cache_mem_way   = scan_way;
                if (scan_entry_dirty) begin
                    next_state = S_FLUSH_WB;
                end else if (scan_last) begin
                    next_state = S_IDLE;
                end
            end
            S_FLUSH_WB: begin
                cache_mem_index = scan_set;
                cache_mem_way   = scan_way;
                mem_wr_req      = 1'b1;
                mem_addr        = {tag_q[scan_set][scan_way], scan_set, {OFF_W{1'b0}}};
                mem_wdata       = cache_mem_rdata;
                if (mem_ready) begin
                    next_state = scan_last ? S_IDLE : S_FLUSH_SCAN;
                end
            end
            default: next_state = S_IDLE;
        endcase

        // Requests and strobes drop in the very first cycle reset is seen
        if (rst) begin
            cpu_resp_valid     = 1'b0;
            cache_mem_write_en = 1'b0;
            mem_rd_req         = 1'b0;
            mem_wr_req         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
            req_tag      <= '0;
            req_set      <= '0;
            req_word     <= '0;
            req_write    <= 1'b0;
            req_wdata    <= '0;
            req_wstrb    <= '0;
            victim_q     <= '0;
            resp_hit_q   <= 1'b0;
            rdata_q      <= '0;
            flush_done_q <= 1'b0;
            scan_set     <= '0;
            scan_way     <= '0;
        end else begin
            flush_done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (flush_req) begin
                        scan_set <= '0;
                        scan_way <= '0;
                    end else if (cpu_req_valid) begin
                        req_tag   <= cpu_addr[ADDR_W-1:IDX_W+OFF_W];
                        req_set   <= cpu_addr[IDX_W+OFF_W-1:OFF_W];
                        req_word  <= cpu_addr[OFF_W-1:2];
                        req_write <= cpu_req_write;
                        req_wdata <= cpu_wdata;
                        req_wstrb <= cpu_wstrb;
                    end
                end
                S_LOOKUP: begin
                    resp_hit_q <= lookup_hit;
                    victim_q   <= victim_sel;
                    if (lookup_hit) begin
                        if (req_write) begin
                            dirty_q[req_set][hit_way] <= 1'b1;
                        end else begin
                            rdata_q <= cache_mem_rdata[{req_word, 5'b0} +: 32];
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ready) begin
                        dirty_q[req_set][victim_q] <= 1'b0;
                    end
                end
                S_REFILL: begin
                    if (mem_ready) begin
                        tag_q[req_set][victim_q]   <= req_tag;
                        valid_q[req_set][victim_q] <= 1'b1;
                        dirty_q[req_set][victim_q] <= req_write;
                        rr_q[req_set]              <= rr_next;
                        rdata_q                    <= merged_line[{req_word, 5'b0} +: 32];
                    end
                end
                default: ;
            endcase

            if (scan_adv) begin
                valid_q[scan_set][scan_way] <= 1'b0;
                dirty_q[scan_set][scan_way] <= 1'b0;
                if (scan_last) begin
                    flush_done_q <= 1'b1;
                    scan_set     <= '0;
                    scan_way     <= '0;
                    for (int s = 0; s < SETS; s++) begin
                        rr_q[s] <= '0;
                    end
                end else if (scan_way == WAY_W'(WAYS - 1)) begin
                    scan_way <= '0;
                    scan_set <= scan_set + 1'b1;
                end else begin
                    scan_way <= scan_way + 1'b1;
                end
            end
        end
    end

    assign cpu_rdata  = rdata_q;
    assign cpu_hit    = resp_hit_q;
    assign flush_done = flush_done_q;

endmodule

// File: tb/tb_cache_controller_nway_wb.sv
// tb/tb_cache_controller_nway_wb.sv - scoreboard bench for cache_controller_nway_wb
module tb_cache_controller_nway_wb;

    localparam int ADDR_W     = 32;
    localparam int LINE_BYTES = 64;
    localparam int SETS       = 64;
    localparam int WAYS       = 2;
    localparam int IDX_W      = 6;
    localparam int WAY_W      = 1;
    localparam int LINE_W     = 512;

    logic                  clk;
    logic                  rst;
    logic                  cpu_req_valid;
    logic                  cpu_req_write;
    logic [ADDR_W-1:0]     cpu_addr;
    logic [31:0]           cpu_wdata;
    logic [3:0]            cpu_wstrb;
    logic                  cpu_ready;
    logic                  cpu_resp_valid;
    logic [31:0]           cpu_rdata;
    logic                  cpu_hit;
    logic                  flush_req;
    logic                  flush_done;
    logic [IDX_W-1:0]      cache_mem_index;
    logic [WAY_W-1:0]      cache_mem_way;
    logic [LINE_W-1:0]     cache_mem_wdata;
    logic [LINE_BYTES-1:0] cache_mem_wstrb;
    logic                  cache_mem_write_en;
    logic [LINE_W-1:0]     cache_mem_rdata;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_rd_req;
    logic                  mem_wr_req;
    logic [LINE_W-1:0]     mem_wdata;
    logic [LINE_W-1:0]     mem_rdata;
    logic                  mem_ready;

    cache_controller_nway_wb #(
        .ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .SETS(SETS), .WAYS(WAYS)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid),
        .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .flush_req(flush_req), .flush_done(flush_done),
        .cache_mem_index(cache_mem_index), .cache_mem_way(cache_mem_way),
        .cache_mem_wdata(cache_mem_wdata), .cache_mem_wstrb(cache_mem_wstrb),
        .cache_mem_write_en(cache_mem_write_en), .cache_mem_rdata(cache_mem_rdata),
        .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // External data array model
    logic [LINE_W-1:0]     darr [SETS][WAYS];
    logic [LINE_BYTES-1:0] last_wstrb;
    logic [WAY_W-1:0]      last_way;

    assign cache_mem_rdata = darr[cache_mem_index][cache_mem_way];

    always @(posedge clk) begin
        if (cache_mem_write_en) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (cache_mem_wstrb[b]) begin
                    darr[cache_mem_index][cache_mem_way][8*b +: 8] <= cache_mem_wdata[8*b +: 8];
                end
            end
            last_wstrb <= cache_mem_wstrb;
            last_way   <= cache_mem_way;
        end
    end

    // Main memory model: unwritten lines hold word i = line address + 4*i
    logic [LINE_W-1:0] mem_store [logic [31:0]];
    int mem_lat = 1;
    int mcnt    = 0;

    function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] a);
        logic [LINE_W-1:0] l;
        if (mem_store.exists(a)) return mem_store[a];
        for (int i = 0; i < LINE_BYTES / 4; i++) l[32*i +: 32] = a + 32'(4 * i);
        return l;
    endfunction

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        int          len;
        bit          chk;
        int          word;
        logic [31:0] val;
    } mexp_t;

    typedef struct {
        logic [31:0] rdata;
        bit          hit;
        bit          chk;
    } rexp_t;

    mexp_t mq[$];
    rexp_t rq[$];
    int    fd_cnt = 0;

    // Memory responder and handshake scoreboard
    initial begin
        mexp_t e;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ready) mcnt = 0;
            mem_ready = 1'b0;
            if (!rst && (mem_rd_req || mem_wr_req)) begin
                mcnt++;
                if (mcnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    if (mem_rd_req) mem_rdata = mem_line(mem_addr);
                    if (mem_wr_req) mem_store[mem_addr] = mem_wdata;
                    check("mem_rd_wr_exclusive", 64'(mem_rd_req & mem_wr_req), 64'd0);
                    if (mq.size() == 0) begin
                        check("mem_unexpected_req", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = mq.pop_front();
                        check("mem_is_write", 64'(mem_wr_req), 64'(e.wr));
                        check("mem_addr", 64'(mem_addr), 64'(e.addr));
                        check("mem_req_len", 64'(mcnt), 64'(e.len));
                        if (e.chk) check("mem_wdata_word", 64'(mem_wdata[32*e.word +: 32]), 64'(e.val));
                    end
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // Response monitor
    initial begin
        rexp_t r;
        forever begin
            @(negedge clk);
            if (flush_done) fd_cnt++;
            if (cpu_resp_valid) begin
                if (rq.size() == 0) begin
                    check("resp_unexpected", 64'(cpu_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    r = rq.pop_front();
                    check("resp_hit", 64'(cpu_hit), 64'(r.hit));
                    if (r.chk) check("resp_rdata", 64'(cpu_rdata), 64'(r.rdata));
                end
            end
        end
    end

    function automatic mexp_t mx(input bit wr, input logic [31:0] a, input int len,
                                 input bit chk, input int word, input logic [31:0] val);
        mexp_t e;
        e.wr = wr; e.addr = a; e.len = len; e.chk = chk; e.word = word; e.val = val;
        return e;
    endfunction

    // Issue one request; latency counts clock edges from the accept edge
    // until cpu_resp_valid is visible (hit = 2).
    task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input logic [31:0] exp_rd, input bit exp_hit,
                          input bit chk, input int exp_lat);
        rexp_t r;
        int n;
        n = 0;
        while (!cpu_ready && n < 100) begin @(negedge clk); n++; end
        r.rdata = exp_rd; r.hit = exp_hit; r.chk = chk;
        rq.push_back(r);
        cpu_req_valid = 1'b1; cpu_req_write = wr; cpu_addr = a; cpu_wdata = wd; cpu_wstrb = st;
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        n = 1;
        while (!cpu_resp_valid && n < 400) begin @(posedge clk); @(negedge clk); n++; end
        check("resp_latency", 64'(n), 64'(exp_lat));
    endtask

    task automatic do_flush(input int exp_lat);
        int n;
        n = 0;
        while (!cpu_ready && n < 100) begin @(negedge clk); n++; end
        flush_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush_req = 1'b0;
        n = 1;
        while (!flush_done && n < 2000) begin @(posedge clk); @(negedge clk); n++; end
        check("flush_latency", 64'(n), 64'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LINE_W-1:0] l;
        int fd0;
        rst = 1'b1;
        cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_addr = '0;
        cpu_wdata = '0; cpu_wstrb = '0; flush_req = 1'b0;

        l = mem_line(32'h0000_1040);
        l[31:0]  = 32'hDEAD_BEEF;
        l[63:32] = 32'hA5A5_1111;
        mem_store[32'h0000_1040] = l;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_ready", 64'(cpu_ready), 64'd1);
        check("rst_resp_valid", 64'(cpu_resp_valid), 64'd0);
        check("rst_mem_rd_req", 64'(mem_rd_req), 64'd0);
        check("rst_mem_wr_req", 64'(mem_wr_req), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        check("rst_index", 64'(cache_mem_index), 64'd0);
        check("rst_write_en", 64'(cache_mem_write_en), 64'd0);
        check("rst_rdata", 64'(cpu_rdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Cold read, L=3, then the same read hits
        mem_lat = 3;
        mq.push_back(mx(1'b0, 32'h0000_1040, 3, 1'b0, 0, 32'h0));
        do_req(1'b0, 32'h0000_1040, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 5);
        do_req(1'b0, 32'h0000_1040, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 1'b1, 2);

        // Write hit, low half of word 1
        do_req(1'b1, 32'h0000_1044, 32'h1234_5678, 4'b0011, 32'h0, 1'b1, 1'b0, 2);
        check("write_hit_wstrb", 64'(last_wstrb), 64'h0000_0000_0000_0030);
        do_req(1'b0, 32'h0000_1044, 32'h0, 4'h0, 32'hA5A5_5678, 1'b1, 1'b1, 2);

        // Fill way1 of set 1, then evict dirty way0
        mem_lat = 2;
        mq.push_back(mx(1'b0, 32'h0000_2040, 2, 1'b0, 0, 32'h0));
        do_req(1'b0, 32'h0000_2040, 32'h0, 4'h0, 32'h0000_2040, 1'b0, 1'b1, 4);
        mq.push_back(mx(1'b1, 32'h0000_1040, 2, 1'b1, 1, 32'hA5A5_5678));
        mq.push_back(mx(1'b0, 32'h0000_3040, 2, 1'b0, 0, 32'h0));
        do_req(1'b0, 32'h0000_3040, 32'h0, 4'h0, 32'h0000_3040, 1'b0, 1'b1, 6);
        check("evict_refill_way", 64'(last_way), 64'd0);
        check("refill_wstrb_all", 64'(last_wstrb), 64'hFFFF_FFFF_FFFF_FFFF);

        // Pointer now 1: next miss in set 1 replaces way1 (clean, no writeback)
        mem_lat = 1;
        mq.push_back(mx(1'b0, 32'h0000_1040, 1, 1'b0, 0, 32'h0));
        do_req(1'b0, 32'h0000_1040, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 3);
        check("ptr_victim_way", 64'(last_way), 64'd1);
        do_req(1'b0, 32'h0000_3040, 32'h0, 4'h0, 32'h0000_3040, 1'b1, 1'b1, 2);

        // Write miss with merge, then hit on it
        mq.push_back(mx(1'b0, 32'h0000_5080, 1, 1'b0, 0, 32'h0));
        do_req(1'b1, 32'h0000_5080, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0, 1'b0, 3);
        do_req(1'b0, 32'h0000_5080, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1, 1'b1, 2);
        do_req(1'b1, 32'h0000_3048, 32'h0BAD_F00D, 4'b1111, 32'h0, 1'b1, 1'b0, 2);

        // Flush with two dirty lines: 128 scan cycles + 2 writebacks of 2 cycles
        mem_lat = 2;
        mq.push_back(mx(1'b1, 32'h0000_3040, 2, 1'b1, 2, 32'h0BAD_F00D));
        mq.push_back(mx(1'b1, 32'h0000_5080, 2, 1'b1, 0, 32'hCAFE_F00D));
        fd0 = fd_cnt;
        do_flush(133);
        repeat (3) @(negedge clk);
        check("flush_done_pulses", 64'(fd_cnt - fd0), 64'd1);

        mem_lat = 1;
        mq.push_back(mx(1'b0, 32'h0000_3040, 1, 1'b0, 0, 32'h0));
        do_req(1'b0, 32'h0000_3048, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b1, 3);
        mq.push_back(mx(1'b0, 32'h0000_5080, 1, 1'b0, 0, 32'h0));
        do_req(1'b0, 32'h0000_5080, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b1, 3);
        mq.push_back(mx(1'b0, 32'h0000_1040, 1, 1'b0, 0, 32'h0));
        do_req(1'b0, 32'h0000_1040, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 3);

        // Reset during a stalled refill
        mem_lat = 1000;
        while (!cpu_ready) @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_addr = 32'h0000_6100;
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("refill_rd_req", 64'(mem_rd_req), 64'd1);
        check("refill_addr", 64'(mem_addr), 64'h0000_6100);
        rst = 1'b1;
        #1;
        check("rst_drops_rd_req", 64'(mem_rd_req), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_lat = 1;
        check("post_rst_ready", 64'(cpu_ready), 64'd1);
        mq.push_back(mx(1'b0, 32'h0000_6100, 1, 1'b0, 0, 32'h0));
        do_req(1'b0, 32'h0000_6100, 32'h0, 4'h0, 32'h0000_6100, 1'b0, 1'b1, 3);

        repeat (3) @(negedge clk);
        check("resp_queue_empty", 64'(rq.size()), 64'd0);
        check("mem_queue_empty", 64'(mq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
